approx_mult_pipe: RTL and testbench

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pipe.sv | 185 ++++++++++++++++++
 tb/tb_approx_mult_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Purpose  : Two-stage approximate multiplier. It builds four half-width
//            partial products, then combines them as exact, OR or truncated.
// Options  : define APPROX_MULT_ERR_MON_EN to add the error accumulator
//            (ports err_clr / err_acc).
// Revision : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
   parameter int W    = 8,
   parameter int ID_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic [1:0]      mode,
   input  logic [ID_W-1:0] in_id,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  R,
   output logic [ID_W-1:0] out_id
`ifdef APPROX_MULT_ERR_MON_EN
   ,
   input  logic            err_clr,
   output logic [31:0]     err_acc
`endif
);

   localparam int c_H  = W / 2;
   localparam int c_RW = 2 * W;

   localparam logic [1:0] c_MODE_OR    = 2'b01;
   localparam logic [1:0] c_MODE_TRUNC = 2'b10;

   // ------------------------------------------------------------------
   // Flow control: a single advance enable for the whole pipe
   // ------------------------------------------------------------------
   logic w_adv;

   assign w_adv    = out_ready || !out_valid;
   assign in_ready = w_adv;

   // ------------------------------------------------------------------
   // Stage 1: half-width partial products
   // ------------------------------------------------------------------
   logic [W-1:0] w_al;
   logic [W-1:0] w_ah;
   logic [W-1:0] w_bl;
   logic [W-1:0] w_bh;

   // Halves are zero-extended to W so each product keeps its full 2H bits
   assign w_al = {{(W-c_H){1'b0}}, A[c_H-1:0]};
   assign w_ah = {{(W-c_H){1'b0}}, A[W-1:c_H]};
   assign w_bl = {{(W-c_H){1'b0}}, B[c_H-1:0]};
   assign w_bh = {{(W-c_H){1'b0}}, B[W-1:c_H]};

   logic            r_s1_valid;
   logic [W-1:0]    r_pll;
   logic [W-1:0]    r_plh;
   logic [W-1:0]    r_phl;
   logic [W-1:0]    r_phh;
   logic [1:0]      r_s1_mode;
   logic [ID_W-1:0] r_s1_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_pll      <= '0;
         r_plh      <= '0;
         r_phl      <= '0;
         r_phh      <= '0;
         r_s1_mode  <= '0;
         r_s1_id    <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_pll     <= w_al * w_bl;
            r_plh     <= w_al * w_bh;
            r_phl     <= w_ah * w_bl;
            r_phh     <= w_ah * w_bh;
            r_s1_mode <= mode;
            r_s1_id   <= in_id;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: combine partial products according to the captured mode
   // ------------------------------------------------------------------
   logic [c_RW-1:0] w_hh;
   logic [c_RW-1:0] w_ll;
   logic [c_RW-1:0] w_cross;
   logic [c_RW-1:0] w_mid;
   logic [c_RW-1:0] w_exact;
   logic [c_RW-1:0] w_trunc;
   logic [c_RW-1:0] w_or;
   logic [c_RW-1:0] w_res;

   assign w_hh    = {r_phh, {W{1'b0}}};
   assign w_ll    = {{W{1'b0}}, r_pll};
   assign w_cross = {{W{1'b0}}, r_plh} + {{W{1'b0}}, r_phl};
   assign w_mid   = w_cross << c_H;
   assign w_exact = w_hh + w_mid + w_ll;
   assign w_trunc = w_hh + w_mid;
   assign w_or    = {r_phh, r_pll} | ({{W{1'b0}}, (r_plh | r_phl)} << c_H);

   always_comb begin
      w_res = w_exact;
      case (r_s1_mode)
         c_MODE_OR:    w_res = w_or;
         c_MODE_TRUNC: w_res = w_trunc;
         default:      w_res = w_exact;
      endcase
   end

   logic            r_out_valid;
   logic [c_RW-1:0] r_r;
   logic [ID_W-1:0] r_out_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_r         <= '0;
         r_out_id    <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_r      <= w_res;
            r_out_id <= r_s1_id;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign R         = r_r;
   assign out_id    = r_out_id;

`ifdef APPROX_MULT_ERR_MON_EN
   // ------------------------------------------------------------------
   // Error monitor: sums |exact - R| over retired results, saturating
   // ------------------------------------------------------------------
   localparam int c_SW = ((c_RW > 32) ? c_RW : 32) + 1;

   logic [c_RW-1:0] w_diff;
   logic [c_RW-1:0] r_err_diff;
   logic [31:0]     r_err_acc;
   logic [c_SW-1:0] w_err_sum;
   logic            w_retire;

   assign w_diff    = (w_exact >= w_res) ? (w_exact - w_res) : (w_res - w_exact);
   assign w_retire  = r_out_valid && out_ready;
   assign w_err_sum = c_SW'(r_err_acc) + c_SW'(r_err_diff);

   // The error of the result sitting in R travels with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_diff <= '0;
      end else if (w_adv && r_s1_valid) begin
         r_err_diff <= w_diff;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_acc <= '0;
      end else if (err_clr) begin
         r_err_acc <= '0;
      end else if (w_retire) begin
         if (w_err_sum[c_SW-1:32] != '0) begin
            r_err_acc <= 32'hFFFF_FFFF;
         end else begin
            r_err_acc <= w_err_sum[31:0];
         end
      end
   end

   assign err_acc = r_err_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mult_pipe
// Purpose  : Randomized, model-checked bench for approx_mult_pipe (W=8 and W=16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

   localparam int W    = 8;
   localparam int ID_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // W=8 instance
   logic            in_valid  = 1'b0;
   logic            in_ready;
   logic [W-1:0]    A         = '0;
   logic [W-1:0]    B         = '0;
   logic [1:0]      mode      = '0;
   logic [ID_W-1:0] in_id     = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2*W-1:0]  R;
   logic [ID_W-1:0] out_id;

   // W=16 instance
   logic            v16   = 1'b0;
   logic            ir16;
   logic [15:0]     a16   = '0;
   logic [15:0]     b16   = '0;
   logic [1:0]      m16   = '0;
   logic [ID_W-1:0] id16  = '0;
   logic            ov16;
   logic            or16  = 1'b1;
   logic [31:0]     r16;
   logic [ID_W-1:0] oid16;

`ifdef APPROX_MULT_ERR_MON_EN
   logic        ec16 = 1'b0;
   logic [31:0] ea8;
   logic [31:0] ea16;
   longint      err8_model  = 0;
   longint      err16_model = 0;
`endif

   approx_mult_pipe #(.W(W), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mode      (mode),
      .in_id     (in_id),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R),
      .out_id    (out_id)
`ifdef APPROX_MULT_ERR_MON_EN
      ,
      .err_clr   (1'b0),
      .err_acc   (ea8)
`endif
   );

   approx_mult_pipe #(.W(16), .ID_W(ID_W)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v16),
      .in_ready  (ir16),
      .A         (a16),
      .B         (b16),
      .mode      (m16),
      .in_id     (id16),
      .out_valid (ov16),
      .out_ready (or16),
      .R         (r16),
      .out_id    (oid16)
`ifdef APPROX_MULT_ERR_MON_EN
      ,
      .err_clr   (ec16),
      .err_acc   (ea16)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      longint          r;
      longint          exact;
      logic [ID_W-1:0] id;
   } exp_t;

   exp_t            q[$];
   logic            hold_vld = 1'b0;
   logic [2*W-1:0]  hold_r   = '0;
   logic [ID_W-1:0] hold_id  = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference product straight from the half-word definitions
   function automatic longint ref_mult(input longint a, input longint b, input int w,
                                       input logic [1:0] m);
      int     h;
      longint msk, al, ah, bl, bh;
      h   = w / 2;
      msk = (longint'(1) << h) - 1;
      al  = a & msk;
      ah  = a >> h;
      bl  = b & msk;
      bh  = b >> h;
      case (m)
         2'b01:   return ((ah * bh) << w) | (al * bl) | (((al * bh) | (ah * bl)) << h);
         2'b10:   return a * b - al * bl;
         default: return a * b;
      endcase
   endfunction

   function automatic longint sat_add(input longint acc, input longint d);
      return (acc + d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : acc + d;
   endfunction

   // One W=8 cycle: drive at negedge, then score handshakes before the next posedge
   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] m, input logic [ID_W-1:0] id,
                       input logic ordy, output logic acc);
      exp_t e;
      @(negedge clk);
`ifdef APPROX_MULT_ERR_MON_EN
      check("err_acc8", 64'(ea8), 64'(err8_model));
`endif
      in_valid  = iv;
      A         = a;
      B         = b;
      mode      = m;
      in_id     = id;
      out_ready = ordy;
      #1;
      check("in_ready", 64'(in_ready), 64'(out_ready || !out_valid));
      if (hold_vld) begin
         check("stall_valid", 64'(out_valid), 64'(1));
         check("stall_R", 64'(R), 64'(hold_r));
         check("stall_id", 64'(out_id), 64'(hold_id));
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'(0));
         end else begin
            e = q.pop_front();
            check("R", 64'(R), 64'(e.r));
            check("out_id", 64'(out_id), 64'(e.id));
`ifdef APPROX_MULT_ERR_MON_EN
            err8_model = sat_add(err8_model, e.exact - e.r);
`endif
         end
      end
      hold_vld = out_valid && !out_ready;
      hold_r   = R;
      hold_id  = out_id;
      acc      = in_valid && in_ready;
      if (acc) q.push_back('{r: ref_mult(longint'(a), longint'(b), W, m),
                             exact: ref_mult(longint'(a), longint'(b), W, 2'b00), id: id});
   endtask

   // One isolated W=16 operation with out_ready held high
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                       input logic clr, input string tag, output longint got);
      int     n;
      longint e;
      e = ref_mult(longint'(a), longint'(b), 16, m);
      @(negedge clk);
      v16  = 1'b1;
      a16  = a;
      b16  = b;
      m16  = m;
      id16 = id16 + 1'b1;
      or16 = 1'b1;
      @(negedge clk);
      v16 = 1'b0;
      n   = 0;
      while (!ov16 && n < 8) begin
         @(negedge clk);
         n++;
      end
      got = longint'(r16);
      check({tag, "_lat"}, 64'(n), 64'(1));
      check(tag, 64'(r16), 64'(e));
      check({tag, "_id"}, 64'(oid16), 64'(id16));
`ifdef APPROX_MULT_ERR_MON_EN
      ec16        = clr;
      err16_model = clr ? 0 : sat_add(err16_model, ref_mult(longint'(a), longint'(b), 16, 2'b00) - e);
      @(negedge clk);
      ec16 = 1'b0;
      check({tag, "_err"}, 64'(ea16), 64'(err16_model));
`else
      if (clr) @(negedge clk);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         acc;
      int           idx;
      int           cyc;
      longint       got;
      logic [W-1:0] sa[16];
      logic [W-1:0] sb[16];
      logic [1:0]   sm[16];

      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_R", 64'(R), 64'(0));
      check("rst_out_id", 64'(out_id), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
      check("in_ready_after_rst", 64'(in_ready), 64'(1));

      // 0xFF*0xFF exact with two-cycle latency
      step(1'b1, 8'hFF, 8'hFF, 2'b00, 4'h1, 1'b1, acc);
      check("acc_ff", 64'(acc), 64'(1));
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
      check("lat_cycle1", 64'(out_valid), 64'(0));
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
      check("lat_cycle2", 64'(out_valid), 64'(1));
      check("R_ff_exact", 64'(R), 64'(16'hFE01));

      // OR and truncate modes back to back
      step(1'b1, 8'hFF, 8'hFF, 2'b01, 4'h2, 1'b1, acc);
      step(1'b1, 8'hFF, 8'hFF, 2'b10, 4'h3, 1'b1, acc);
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
      check("R_ff_or", 64'(R), 64'(16'hEFF1));
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
      check("R_ff_trunc", 64'(R), 64'(16'hFD20));
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
`ifdef APPROX_MULT_ERR_MON_EN
      check("err_acc_or_trunc", 64'(ea8), 64'(32'h0E10 + 32'h00E1));
`endif

      // 16-pair stream with a stall in cycles 3..6
      foreach (sa[i]) begin
         sa[i] = W'($urandom);
         sb[i] = W'($urandom);
         sm[i] = 2'($urandom);
      end
      idx = 0;
      cyc = 0;
      while ((idx < 16 || q.size() != 0) && cyc < 100) begin
         step(idx < 16, sa[idx % 16], sb[idx % 16], sm[idx % 16], ID_W'(idx),
              !(cyc >= 3 && cyc <= 6), acc);
         if (acc) idx++;
         cyc++;
      end
      check("stream_drain", 64'(idx == 16 && q.size() == 0), 64'(1));

      // Random valid/ready traffic
      repeat (300) begin
         step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom),
              ID_W'($urandom), $urandom_range(0, 3) != 0, acc);
      end
      cyc = 0;
      while (q.size() != 0 && cyc < 50) begin
         step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
         cyc++;
      end
      check("random_drain", 64'(q.size()), 64'(0));

      // Reset with two transactions in flight
      step(1'b1, 8'h12, 8'h34, 2'b00, 4'h5, 1'b1, acc);
      step(1'b1, 8'h56, 8'h78, 2'b01, 4'h6, 1'b1, acc);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'(0));
      check("rst_mid_R", 64'(R), 64'(0));
      check("rst_mid_out_id", 64'(out_id), 64'(0));
      q.delete();
      hold_vld = 1'b0;
`ifdef APPROX_MULT_ERR_MON_EN
      err8_model  = 0;
      err16_model = 0;
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
         check("no_stale", 64'(out_valid), 64'(0));
      end

      // W=16 directed and random operations
      op16(16'hFFFF, 16'h0001, 2'b00, 1'b0, "w16_exact", got);
      check("w16_ffff_x1_exact", 64'(got), 64'(32'h0000FFFF));
      op16(16'hFFFF, 16'h0001, 2'b11, 1'b0, "w16_mode3", got);
      check("w16_ffff_x1_mode3", 64'(got), 64'(32'h0000FFFF));
      repeat (6) op16(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, "w16_rand", got);

`ifdef APPROX_MULT_ERR_MON_EN
      // Drive the accumulator into saturation, then clear it on a retire
      repeat (300) op16(16'hFFFF, 16'hFFFF, 2'b01, 1'b0, "w16_sat", got);
      check("err_saturated", 64'(ea16), 64'(32'hFFFF_FFFF));
      op16(16'hFFFF, 16'hFFFF, 2'b01, 1'b1, "w16_clr", got);
      check("err_clr_on_retire", 64'(ea16), 64'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
